// File: rtl/lvds_dci_cal_pkg.sv
// Shared definitions for the LVDS DCI impedance calibration controller:
// FSM state encoding, default parameter values and a counter-width helper.
package lvds_dci_cal_pkg;

  localparam int unsigned DEF_CODE_W       = 6;
  localparam int unsigned DEF_SETTLE       = 8;
  localparam int unsigned DEF_RECAL_PERIOD = 1024;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SAR_SET  = 3'd1,
    ST_SAR_WAIT = 3'd2,
    ST_SAR_EVAL = 3'd3,
    ST_LOCKED   = 3'd4,
    ST_TRK_WAIT = 3'd5,
    ST_TRK_EVAL = 3'd6
  } cal_state_e;

  // Bits needed to hold values 0..max_val, never less than 1.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dci_cmp_sync.sv
// Two-flop synchronizer for the asynchronous reference comparator output.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized).
module dci_cmp_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lvds_dci_cal_ctrl.sv
// DCI impedance calibration controller for an LVDS bank. A START request
// runs a successive-approximation search of the impedance code against the
// reference comparator; once locked, the code is nudged by one step every
// RECAL_PERIOD cycles to track drift. HOLD freezes all sequencing.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        one-cycle full-calibration request
//   cmp          async comparator, 1 = code too low
//   hold         freeze FSM, counters and code
//   code         impedance code to the buffers
//   code_valid   code is a locked result
//   busy         full calibration in progress
//   done         one-cycle pulse at end of full calibration
//   err          sticky: tracking step blocked at a code limit
module lvds_dci_cal_ctrl
  import lvds_dci_cal_pkg::*;
#(
  parameter int unsigned CODE_W       = DEF_CODE_W,
  parameter int unsigned SETTLE       = DEF_SETTLE,
  parameter int unsigned RECAL_PERIOD = DEF_RECAL_PERIOD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cmp,
  input  logic              hold,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned IDX_W = cnt_w(CODE_W - 1);
  localparam int unsigned SET_W = 8;
  localparam int unsigned IVL_W = cnt_w(RECAL_PERIOD);
  localparam logic [CODE_W-1:0] CODE_MAX = '1;

  cal_state_e        state;
  logic [IDX_W-1:0]  idx;
  logic [SET_W-1:0]  settle_cnt;
  logic [IVL_W-1:0]  ivl_cnt;
  logic              cmp_s;
  logic [CODE_W-1:0] bit_mask_c;
  logic              start_ok_c;
  logic              settled_c;

  dci_cmp_sync u_cmp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp),
    .q     (cmp_s)
  );

  // START is honoured only outside the SAR search.
  assign start_ok_c = start && ((state == ST_IDLE) || (state == ST_LOCKED) ||
                                (state == ST_TRK_WAIT) || (state == ST_TRK_EVAL));
  assign bit_mask_c = CODE_W'(1) << idx;
  assign settled_c  = (settle_cnt == SET_W'(SETTLE - 1));

  // Calibration sequencer; HOLD freezes everything except the DONE pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      code       <= '0;
      idx        <= '0;
      settle_cnt <= '0;
      ivl_cnt    <= '0;
      code_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!hold) begin
        if (start_ok_c) begin
          state      <= ST_SAR_SET;
          code       <= '0;
          idx        <= IDX_W'(CODE_W - 1);
          settle_cnt <= '0;
          ivl_cnt    <= '0;
          err        <= 1'b0;
          code_valid <= 1'b0;
          busy       <= 1'b1;
        end else begin
          case (state)
            ST_SAR_SET: begin
              code       <= code | bit_mask_c;
              settle_cnt <= '0;
              state      <= ST_SAR_WAIT;
            end
            ST_SAR_WAIT: begin
              if (settled_c) begin
                settle_cnt <= '0;
                state      <= ST_SAR_EVAL;
              end else begin
                settle_cnt <= settle_cnt + SET_W'(1);
              end
            end
            ST_SAR_EVAL: begin
              if (!cmp_s) code <= code & ~bit_mask_c;
              if (idx == '0) begin
                state      <= ST_LOCKED;
                ivl_cnt    <= '0;
                busy       <= 1'b0;
                code_valid <= 1'b1;
                done       <= 1'b1;
              end else begin
                idx   <= idx - IDX_W'(1);
                state <= ST_SAR_SET;
              end
            end
            ST_LOCKED: begin
              if (RECAL_PERIOD != 0) begin
                if (ivl_cnt == IVL_W'(RECAL_PERIOD - 1)) begin
                  ivl_cnt    <= '0;
                  settle_cnt <= '0;
                  state      <= ST_TRK_WAIT;
                end else begin
                  ivl_cnt <= ivl_cnt + IVL_W'(1);
                end
              end
            end
            ST_TRK_WAIT: begin
              if (settled_c) begin
                settle_cnt <= '0;
                state      <= ST_TRK_EVAL;
              end else begin
                settle_cnt <= settle_cnt + SET_W'(1);
              end
            end
            ST_TRK_EVAL: begin
              // Single saturating step; a blocked step raises the sticky error.
              if (cmp_s) begin
                if (code == CODE_MAX) err <= 1'b1;
                else                  code <= code + CODE_W'(1);
              end else begin
                if (code == '0) err <= 1'b1;
                else            code <= code - CODE_W'(1);
              end
              ivl_cnt <= '0;
              state   <= ST_LOCKED;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lvds_dci_cal_ctrl.sv
// Scoreboard bench for lvds_dci_cal_ctrl with a threshold comparator model.
module tb_lvds_dci_cal_ctrl;

  localparam int unsigned CODE_W = 6;
  localparam int unsigned SETTLE = 8;
  localparam int unsigned RECAL  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start = 1'b0;
  logic              hold = 1'b0;
  logic              cmp;
  logic [CODE_W-1:0] code;
  logic              code_valid, busy, done, err;

  int thr       = 37;
  int cyc       = 0;
  int start_cyc = 0;
  bit start_ref = 1'b0;
  int n_vec     = 0;
  int n_err     = 0;

  typedef struct {
    bit is_done;
    int code;
    bit err;
    int lat;
  } exp_t;
  exp_t sb[$];

  logic [CODE_W-1:0] prev_code = '0;
  logic              prev_err  = 1'b0;

  // Reference comparator: code too low while code <= threshold.
  always_comb cmp = (int'(code) <= thr);

  lvds_dci_cal_ctrl #(
    .CODE_W       (CODE_W),
    .SETTLE       (SETTLE),
    .RECAL_PERIOD (RECAL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cmp        (cmp),
    .hold       (hold),
    .code       (code),
    .code_valid (code_valid),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void exp_push(input bit d, input int c, input bit e, input int l);
    exp_t x;
    x.is_done = d;
    x.code    = c;
    x.err     = e;
    x.lat     = l;
    sb.push_back(x);
  endfunction

  // Reference edge for latency: the rising edge that samples a counted START.
  always @(posedge clk) begin
    if (start && start_ref && !hold) start_cyc = cyc;
  end

  // Monitor: DONE pulses and tracking-visible code/err changes pop the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   ev;
    cyc++;
    ev = 1'b0;
    if (rst_n === 1'b1)
      ev = (done === 1'b1) ||
           ((code_valid === 1'b1) && (busy === 1'b0) &&
            ((code !== prev_code) || (err === 1'b1 && prev_err === 1'b0)));
    if (ev) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: code=%0d done=%0b err=%0b, expected no output",
                 code, done, err);
      end else begin
        e = sb.pop_front();
        chk("done_flag", int'(done), int'(e.is_done));
        chk("code", int'(code), e.code);
        chk("err", int'(err), int'(e.err));
        chk("code_valid", int'(code_valid), 1);
        chk("busy", int'(busy), 0);
        if (e.is_done) chk("done_latency", cyc - start_cyc, e.lat);
      end
    end
    prev_code = code;
    prev_err  = err;
  end

  task automatic pulse_start(input bit counted);
    @(negedge clk);
    start     = 1'b1;
    start_ref = counted;
    @(negedge clk);
    start     = 1'b0;
    start_ref = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_code"}, int'(code), 0);
    chk({tag, "_code_valid"}, int'(code_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end

  initial begin : stim
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Full calibration against threshold 37.
    thr = 37;
    exp_push(1'b1, 37, 1'b0, 61);
    pulse_start(1'b1);
    chk("busy_after_start", int'(busy), 1);
    drain(200);

    // Threshold moves to 39: track 38, 39 then dither 40/39.
    thr = 39;
    exp_push(1'b0, 38, 1'b0, 0);
    exp_push(1'b0, 39, 1'b0, 0);
    exp_push(1'b0, 40, 1'b0, 0);
    exp_push(1'b0, 39, 1'b0, 0);
    exp_push(1'b0, 40, 1'b0, 0);
    drain(200);

    // Comparator stuck high: SAR saturates at 63, tracking flags ERR.
    thr = 63;
    exp_push(1'b1, 63, 1'b0, 61);
    exp_push(1'b0, 63, 1'b1, 0);
    pulse_start(1'b1);
    drain(200);
    chk("err_sticky", int'(err), 1);
    chk("code_held_at_max", int'(code), 63);

    // New START clears ERR.
    thr = 37;
    exp_push(1'b1, 37, 1'b0, 61);
    pulse_start(1'b1);
    chk("err_cleared_by_start", int'(err), 0);
    drain(200);

    // HOLD for 5 cycles inside SAR_WAIT of bit 3 delays DONE by 5.
    exp_push(1'b1, 37, 1'b0, 66);
    pulse_start(1'b1);
    repeat (22) @(posedge clk);
    @(negedge clk);
    hold = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("busy_during_hold", int'(busy), 1);
    hold = 1'b0;
    drain(200);

    // Reset during bit 2 of SAR.
    pulse_start(1'b1);
    repeat (33) @(posedge clk);
    @(negedge clk);
    chk("code_before_reset", int'(code), 36);
    rst_n = 1'b0;
    #1 chk_reset_outputs("mid_sar_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_code", int'(code), 0);
    chk("idle_code_valid", int'(code_valid), 0);

    // START during BUSY is ignored: DONE timing and result unchanged.
    exp_push(1'b1, 37, 1'b0, 61);
    pulse_start(1'b1);
    repeat (14) @(posedge clk);
    pulse_start(1'b0);
    chk("busy_after_ignored_start", int'(busy), 1);
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
